alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_pkg.sv | 34 +++
 rtl/alu_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_alu_seq_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and widths for the ALU sequencing controller.
// Holds the FSM state encoding, datapath field widths, the registered
// datapath-control bundle and the EXEC down-counter load helper.
package alu_seq_pkg;

  localparam int DATA_W = 5;
  localparam int OP_W   = 3;
  localparam int SH_W   = 2;
  localparam int FLAG_W = 4;
  localparam int CNT_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_EXEC  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Everything latched on accept and presented to the datapath until the
  // next accept.
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
    logic [SH_W-1:0]   bshift;
    logic              dir;
  } dp_ctrl_t;

  // The EXEC counter counts down to zero, so it is loaded with cycles-1.
  function automatic logic [CNT_W-1:0] exec_load(input int unsigned cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// Purpose: sequences one shift+ALU operation at a time through an external datapath.
// Latency: accept cycle to rsp_valid is 2+EXEC_CYCLES cycles (1+EXEC_CYCLES on a zero-shift skip).
// Backpressure: req_ready only in IDLE; DONE holds rsp_* stable until rsp_ready.
//
// Ports: clk/reset_n (async active-low); req_valid/req_ready with req_a, req_b,
// req_op, req_bshift, req_dir; dp_a/dp_b/dp_ALUControl/dp_bshift/dp_select to the
// datapath, dp_result/dp_flags back from it; rsp_valid/rsp_ready with
// rsp_result/rsp_flags; busy (not IDLE); op_count (completed responses mod 256).
// Optional build macro ALU_SEQ_ZERO_SKIP_EN: an accepted request with
// req_bshift == 0 bypasses SHIFT and goes straight to EXEC.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int EXEC_CYCLES = 1  // datapath settle cycles in EXEC, 1..4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [OP_W-1:0]   req_op,
  input  logic [SH_W-1:0]   req_bshift,
  input  logic              req_dir,
  output logic [DATA_W-1:0] dp_a,
  output logic [DATA_W-1:0] dp_b,
  output logic [OP_W-1:0]   dp_ALUControl,
  output logic [SH_W-1:0]   dp_bshift,
  output logic              dp_select,
  input  logic [DATA_W-1:0] dp_result,
  input  logic [FLAG_W-1:0] dp_flags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic              busy,
  output logic [7:0]        op_count
);

  localparam logic [CNT_W-1:0] EXEC_LOAD = exec_load(EXEC_CYCLES);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  exec_cnt_q, exec_cnt_d;
  dp_ctrl_t          dp_q, dp_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic [FLAG_W-1:0] rsp_flags_q, rsp_flags_d;
  logic [7:0]        op_count_q, op_count_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      exec_cnt_q   <= '0;
      dp_q         <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      exec_cnt_q   <= exec_cnt_d;
      dp_q         <= dp_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      op_count_q   <= op_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    exec_cnt_d   = exec_cnt_q;
    dp_d         = dp_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    op_count_d   = op_count_q;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    busy         = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          dp_d.a      = req_a;
          dp_d.b      = req_b;
          dp_d.op     = req_op;
          dp_d.bshift = req_bshift;
          dp_d.dir    = req_dir;
          // Counter is armed here so both the SHIFT and skip paths enter
          // EXEC with the same count.
          exec_cnt_d  = EXEC_LOAD;
          state_d     = ST_SHIFT;
`ifdef ALU_SEQ_ZERO_SKIP_EN
          if (req_bshift == '0) state_d = ST_EXEC;
`endif
        end
      end
      ST_SHIFT: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (exec_cnt_q == '0) begin
          rsp_result_d = dp_result;
          rsp_flags_d  = dp_flags;
          state_d      = ST_DONE;
        end else begin
          exec_cnt_d = exec_cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          op_count_d = op_count_q + 8'd1;  // wraps silently at 256
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign dp_a          = dp_q.a;
  assign dp_b          = dp_q.b;
  assign dp_ALUControl = dp_q.op;
  assign dp_bshift     = dp_q.bshift;
  assign dp_select     = dp_q.dir;
  assign rsp_result    = rsp_result_q;
  assign rsp_flags     = rsp_flags_q;
  assign op_count      = op_count_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: one instance with EXEC_CYCLES=1 for most scenarios
// and one with EXEC_CYCLES=3 for the mid-EXEC reset and longer latency.
// A behavioural shift/ALU model stands in for the external datapath.
module tb_alu_seq_ctrl;
  import alu_seq_pkg::*;

  localparam int EC  = 1;
  localparam int EC3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, reset_n_3;
  logic       req_valid, req_valid_3, req_ready, req_ready_3;
  logic [4:0] req_a, req_b;
  logic [2:0] req_op;
  logic [1:0] req_bshift;
  logic       req_dir;
  logic [4:0] dp_a, dp_b, dp_a_3, dp_b_3, dp_result, dp_result_3;
  logic [2:0] dp_alu, dp_alu_3;
  logic [1:0] dp_bshift, dp_bshift_3;
  logic       dp_select, dp_select_3;
  logic [3:0] dp_flags, dp_flags_3, rsp_flags, rsp_flags_3;
  logic       rsp_valid, rsp_valid_3, rsp_ready, rsp_ready_3, busy, busy_3;
  logic [4:0] rsp_result, rsp_result_3;
  logic [7:0] op_count, op_count_3;
  logic [4:0] perturb;

  int checks = 0;
  int passed = 0;
  int exp_count = 0;

  // Datapath reference: shift a, select direction, combine with b, derive flags.
  function automatic logic [8:0] dp_model(input logic [4:0] a, input logic [4:0] b,
                                          input logic [2:0] op, input logic [1:0] sh,
                                          input logic dir);
    logic [4:0] s, r;
    logic [3:0] f;
    s = dir ? (a >> sh) : (a << sh);
    case (op)
      3'd0: r = s;
      3'd1: r = s & b;
      3'd2: r = s | b;
      3'd3: r = s + b;
      3'd4: r = s - b;
      3'd5: r = s ^ b;
      3'd6: r = ~s;
      default: r = b;
    endcase
    f = {r == 5'd0, r[4], ^r, op[0]};
    return {f, r};
  endfunction

  function automatic int exp_lat(input int ec, input logic [1:0] sh);
`ifdef ALU_SEQ_ZERO_SKIP_EN
    if (sh == 2'd0) return 1 + ec;
`endif
    return 2 + ec;
  endfunction

  logic [8:0] dp_out, dp_out_3;
  assign dp_out      = dp_model(dp_a, dp_b, dp_alu, dp_bshift, dp_select);
  assign dp_result   = dp_out[4:0] ^ perturb;
  assign dp_flags    = dp_out[8:5];
  assign dp_out_3    = dp_model(dp_a_3, dp_b_3, dp_alu_3, dp_bshift_3, dp_select_3);
  assign dp_result_3 = dp_out_3[4:0];
  assign dp_flags_3  = dp_out_3[8:5];

  alu_seq_ctrl #(.EXEC_CYCLES(EC)) u_dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_bshift(req_bshift), .req_dir(req_dir),
    .dp_a(dp_a), .dp_b(dp_b), .dp_ALUControl(dp_alu), .dp_bshift(dp_bshift), .dp_select(dp_select),
    .dp_result(dp_result), .dp_flags(dp_flags), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy), .op_count(op_count)
  );

  alu_seq_ctrl #(.EXEC_CYCLES(EC3)) u_dut3 (
    .clk(clk), .reset_n(reset_n_3), .req_valid(req_valid_3), .req_ready(req_ready_3),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_bshift(req_bshift), .req_dir(req_dir),
    .dp_a(dp_a_3), .dp_b(dp_b_3), .dp_ALUControl(dp_alu_3), .dp_bshift(dp_bshift_3),
    .dp_select(dp_select_3), .dp_result(dp_result_3), .dp_flags(dp_flags_3),
    .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready_3), .rsp_result(rsp_result_3),
    .rsp_flags(rsp_flags_3), .busy(busy_3), .op_count(op_count_3)
  );

  // Present a request on the main instance, wait for accept, then for rsp_valid.
  // lat counts cycles from the accept cycle to the first rsp_valid cycle.
  task automatic start_op(input logic [4:0] a, input logic [4:0] b, input logic [2:0] op,
                          input logic [1:0] sh, input logic dir, output int lat, output bit ok);
    int guard;
    guard = 0;
    req_a = a; req_b = b; req_op = op; req_bshift = sh; req_dir = dir;
    req_valid = 1'b1;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    ok  = req_ready;
    lat = 0;
    if (ok) begin
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
      ok = rsp_valid;
    end
    req_valid = 1'b0;
  endtask

  task automatic finish_op(input int hold);
    repeat (hold) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_count++;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (dp_a !== 5'd0 || dp_bshift !== 2'd0 || busy !== 1'b0)
      $display("FAIL reset_async got dp_a=%h sh=%h busy=%b exp 0", dp_a, dp_bshift, busy); else passed++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1; reset_n_3 = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b exp 1", req_ready); else passed++;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_valid_busy got %b%b exp 00", rsp_valid, busy); else passed++;
    checks++; if (op_count !== 8'd0) $display("FAIL reset_op_count got %0d exp 0", op_count); else passed++;
    checks++; if ({dp_a, dp_b, dp_alu, dp_bshift, dp_select} !== 20'd0)
      $display("FAIL reset_dp got %h exp 0", {dp_a, dp_b, dp_alu, dp_bshift, dp_select}); else passed++;
    checks++; if ({rsp_result, rsp_flags} !== 9'd0)
      $display("FAIL reset_rsp got %h exp 0", {rsp_result, rsp_flags}); else passed++;
    checks++; if (req_ready_3 !== 1'b1 || op_count_3 !== 8'd0)
      $display("FAIL reset_dut3 got rdy=%b cnt=%0d exp 1/0", req_ready_3, op_count_3); else passed++;
  endtask

  task automatic test_basic();
    int lat;
    req_a = 5'h03; req_b = 5'h01; req_op = 3'b000; req_bshift = 2'd2; req_dir = 1'b0;
    req_valid = 1'b1;
    checks++; if (req_ready !== 1'b1) $display("FAIL basic_accept got %b exp 1", req_ready); else passed++;
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (dp_bshift !== 2'd2 || dp_select !== 1'b0 || dp_a !== 5'h03)
      $display("FAIL basic_dp got sh=%0d sel=%b a=%h exp 2/0/03", dp_bshift, dp_select, dp_a); else passed++;
    checks++; if (busy !== 1'b1 || req_ready !== 1'b0)
      $display("FAIL basic_busy got busy=%b rdy=%b exp 1/0", busy, req_ready); else passed++;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    checks++; if (lat !== 3) $display("FAIL basic_latency got %0d exp 3", lat); else passed++;
    checks++; if (rsp_result !== 5'h0C || rsp_flags !== 4'b0000)
      $display("FAIL basic_result got %h/%b exp 0c/0000", rsp_result, rsp_flags); else passed++;
    finish_op(0);
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || op_count !== 8'(exp_count))
      $display("FAIL basic_handshake got v=%b r=%b cnt=%0d exp 0/1/%0d", rsp_valid, req_ready, op_count, exp_count);
    else passed++;
  endtask

  task automatic test_backpressure();
    int lat;
    bit ok;
    logic [4:0] a, b;
    logic [2:0] op;
    logic [1:0] sh;
    logic dir;
    logic [8:0] e;
    a = 5'($urandom); b = 5'($urandom); op = 3'($urandom); sh = 2'($urandom_range(1, 3));
    dir = 1'($urandom);
    e = dp_model(a, b, op, sh, dir);
    start_op(a, b, op, sh, dir, lat, ok);
    checks++; if (!ok) $display("FAIL bp_timeout got no response exp response"); else passed++;
    for (int i = 0; i < 5; i++) begin
      perturb = 5'($urandom_range(1, 31));
      @(negedge clk);
      checks++; if (rsp_result !== e[4:0] || rsp_valid !== 1'b1 || req_ready !== 1'b0)
        $display("FAIL bp_hold%0d got %h v=%b r=%b exp %h 1 0", i, rsp_result, rsp_valid, req_ready, e[4:0]);
      else passed++;
    end
    perturb = 5'd0;
    checks++; if (op_count !== 8'(exp_count)) $display("FAIL bp_count_before got %0d exp %0d", op_count, exp_count); else passed++;
    finish_op(0);
    checks++; if (op_count !== 8'(exp_count)) $display("FAIL bp_count_after got %0d exp %0d", op_count, exp_count); else passed++;
  endtask

  task automatic test_early_ready();
    int lat;
    bit ok;
    logic [8:0] e;
    rsp_ready = 1'b1;  // held high from IDLE onward
    e = dp_model(5'h11, 5'h07, 3'd3, 2'd1, 1'b1);
    start_op(5'h11, 5'h07, 3'd3, 2'd1, 1'b1, lat, ok);
    checks++; if (!ok || rsp_result !== e[4:0] || op_count !== 8'(exp_count))
      $display("FAIL early_result got ok=%b %h cnt=%0d exp %h %0d", ok, rsp_result, op_count, e[4:0], exp_count);
    else passed++;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_count++;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || op_count !== 8'(exp_count))
      $display("FAIL early_one_cycle got v=%b r=%b cnt=%0d exp 0/1/%0d", rsp_valid, req_ready, op_count, exp_count);
    else passed++;
  endtask

  task automatic test_busy_request();
    int lat, guard, bad;
    bit ok;
    logic [4:0] a0, b0;
    a0 = 5'($urandom); b0 = 5'($urandom);
    req_a = a0; req_b = b0; req_op = 3'd5; req_bshift = 2'd1; req_dir = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    guard = 0; bad = 0;
    while (!rsp_valid && guard < 20) begin
      req_a = ~a0; req_b = 5'($urandom); req_valid = 1'($urandom);
      @(negedge clk);
      guard++;
      if (dp_a !== a0 || dp_b !== b0) bad++;
    end
    req_valid = 1'b1;
    repeat (2) @(negedge clk);
    if (dp_a !== a0) bad++;
    req_valid = 1'b0;
    finish_op(0);
    checks++; if (bad !== 0 || guard >= 20) $display("FAIL busy_dp_hold got %0d changes exp 0", bad); else passed++;
    @(negedge clk);
    checks++; if (dp_a !== a0 || req_ready !== 1'b1)
      $display("FAIL busy_idle_hold got a=%h r=%b exp %h 1", dp_a, req_ready, a0); else passed++;
    start_op(~a0, 5'd2, 3'd0, 2'd0, 1'b1, lat, ok);
    checks++; if (!ok || dp_a !== ~a0) $display("FAIL busy_next_accept got %h exp %h", dp_a, ~a0); else passed++;
    finish_op(1);
  endtask

  task automatic test_zero_skip();
    int lat;
    bit ok;
    start_op(5'h0A, 5'h03, 3'd2, 2'd0, 1'b0, lat, ok);
`ifdef ALU_SEQ_ZERO_SKIP_EN
    checks++; if (!ok || lat !== 2) $display("FAIL zero_skip_lat got %0d exp 2", lat); else passed++;
`else
    checks++; if (!ok || lat !== 3) $display("FAIL zero_skip_lat got %0d exp 3", lat); else passed++;
`endif
    checks++; if (rsp_result !== 5'h0B) $display("FAIL zero_skip_result got %h exp 0b", rsp_result); else passed++;
    finish_op(0);
  endtask

  task automatic test_random();
    int lat;
    bit ok;
    logic [4:0] a, b;
    logic [2:0] op;
    logic [1:0] sh;
    logic dir;
    logic [8:0] e;
    for (int i = 0; i < 40; i++) begin
      a = 5'($urandom); b = 5'($urandom); op = 3'($urandom); sh = 2'($urandom); dir = 1'($urandom);
      e = dp_model(a, b, op, sh, dir);
      start_op(a, b, op, sh, dir, lat, ok);
      checks++; if (!ok || lat !== exp_lat(EC, sh))
        $display("FAIL rnd%0d_lat got ok=%b %0d exp %0d", i, ok, lat, exp_lat(EC, sh)); else passed++;
      checks++; if ({rsp_flags, rsp_result} !== e)
        $display("FAIL rnd%0d_rsp got %h exp %h", i, {rsp_flags, rsp_result}, e); else passed++;
      checks++; if ({dp_a, dp_b, dp_alu, dp_bshift, dp_select} !== {a, b, op, sh, dir})
        $display("FAIL rnd%0d_dp got %h exp %h", i, {dp_a, dp_b, dp_alu, dp_bshift, dp_select}, {a, b, op, sh, dir});
      else passed++;
      finish_op($urandom_range(0, 3));
      checks++; if (op_count !== 8'(exp_count) || busy !== 1'b0)
        $display("FAIL rnd%0d_count got %0d busy=%b exp %0d 0", i, op_count, busy, exp_count); else passed++;
    end
  endtask

  task automatic test_wrap();
    int seen, guard;
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    exp_count = 0;
    checks++; if (op_count !== 8'd0) $display("FAIL wrap_start got %0d exp 0", op_count); else passed++;
    req_a = 5'h05; req_b = 5'h09; req_op = 3'd3; req_bshift = 2'd1; req_dir = 1'b0;
    req_valid = 1'b1; rsp_ready = 1'b1;
    seen = 0; guard = 0;
    while (seen < 256 && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (rsp_valid) seen++;
    end
    checks++; if (op_count !== 8'd255) $display("FAIL wrap_255 got %0d exp 255", op_count); else passed++;
    req_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++; if (seen !== 256 || op_count !== 8'd0 || rsp_valid !== 1'b0)
      $display("FAIL wrap_zero got seen=%0d cnt=%0d v=%b exp 256 0 0", seen, op_count, rsp_valid); else passed++;
  endtask

  task automatic test_reset_mid_exec();
    int pulses, lat;
    logic [8:0] e;
    req_a = 5'($urandom_range(1, 31)); req_b = 5'h1F; req_op = 3'd6; req_bshift = 2'd3; req_dir = 1'b1;
    req_valid_3 = 1'b1;
    @(negedge clk);
    req_valid_3 = 1'b0;
    @(negedge clk);
    checks++; if (busy_3 !== 1'b1 || rsp_valid_3 !== 1'b0 || dp_a_3 !== req_a)
      $display("FAIL mid_exec_pre got busy=%b v=%b a=%h exp 1 0 %h", busy_3, rsp_valid_3, dp_a_3, req_a); else passed++;
    #2 reset_n_3 = 1'b0;
    #1;
    checks++; if ({dp_a_3, dp_b_3, dp_alu_3, dp_bshift_3, dp_select_3, rsp_result_3, rsp_flags_3} !== 29'd0
                  || busy_3 !== 1'b0 || rsp_valid_3 !== 1'b0 || op_count_3 !== 8'd0)
      $display("FAIL mid_exec_reset got dp=%h rsp=%h busy=%b v=%b cnt=%0d exp all 0",
               {dp_a_3, dp_b_3, dp_alu_3, dp_bshift_3, dp_select_3}, {rsp_result_3, rsp_flags_3},
               busy_3, rsp_valid_3, op_count_3);
    else passed++;
    @(negedge clk);
    reset_n_3 = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid_3) pulses++;
    end
    checks++; if (pulses !== 0 || op_count_3 !== 8'd0 || req_ready_3 !== 1'b1)
      $display("FAIL mid_exec_after got pulses=%0d cnt=%0d r=%b exp 0 0 1", pulses, op_count_3, req_ready_3); else passed++;
    e = dp_model(req_a, req_b, req_op, req_bshift, req_dir);
    req_valid_3 = 1'b1;
    @(negedge clk);
    req_valid_3 = 1'b0;
    lat = 1;
    while (!rsp_valid_3 && lat < 20) begin @(negedge clk); lat++; end
    checks++; if (lat !== exp_lat(EC3, req_bshift) || {rsp_flags_3, rsp_result_3} !== e)
      $display("FAIL ec3_op got lat=%0d rsp=%h exp %0d %h", lat, {rsp_flags_3, rsp_result_3}, exp_lat(EC3, req_bshift), e);
    else passed++;
    rsp_ready_3 = 1'b1;
    @(negedge clk);
    rsp_ready_3 = 1'b0;
    checks++; if (op_count_3 !== 8'd1) $display("FAIL ec3_count got %0d exp 1", op_count_3); else passed++;
  endtask

  initial begin
    reset_n = 1'b1; reset_n_3 = 1'b1;
    req_valid = 1'b0; req_valid_3 = 1'b0; rsp_ready = 1'b0; rsp_ready_3 = 1'b0;
    req_a = '0; req_b = '0; req_op = '0; req_bshift = '0; req_dir = 1'b0;
    perturb = '0;
    #2;
    reset_n = 1'b0; reset_n_3 = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_early_ready();
    test_busy_request();
    test_zero_skip();
    test_random();
    test_wrap();
    test_reset_mid_exec();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
